// File: rtl/mover_scheduler_pkg.sv
// Shared definitions for the DataMover scheduler: FSM encoding,
// default sizing and a constant-foldable clog2 helper.
package mover_scheduler_pkg;

  localparam int CNT_DEF  = 31;
  localparam int NREQ_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Number of bits needed to encode n distinct ids (n >= 2).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/mover_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among NREQ requesters, searching
// upward from the slot after the previously served requester.
module rr_arbiter
  import mover_scheduler_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0]        i_req,
  input  logic [clog2(NREQ)-1:0] i_last,
  output logic [NREQ-1:0]        o_gnt,
  output logic [clog2(NREQ)-1:0] o_gnt_id,
  output logic                   o_vld
);

  localparam int IDW = clog2(NREQ);

  logic [IDW-1:0] idx;

  // Walk the ring starting at i_last+1; the first active request wins.
  always_comb begin
    o_gnt    = '0;
    o_gnt_id = '0;
    o_vld    = 1'b0;
    idx      = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = IDW'((int'(i_last) + i) % NREQ);
      if (!o_vld && i_req[idx]) begin
        o_vld      = 1'b1;
        o_gnt[idx] = 1'b1;
        o_gnt_id   = idx;
      end
    end
  end

endmodule

// File: rtl/mover_scheduler.sv
// Scheduler that shares one DataMover among NREQ requesters. A granted
// job is issued with a single run pulse, tracked until the mover reports
// done, then acknowledged back to its owner. Zero-length jobs are
// rejected without touching the mover.
module mover_scheduler
  import mover_scheduler_pkg::*;
#(
  parameter int CNT  = CNT_DEF,
  parameter int NREQ = NREQ_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        i_req,
  input  logic [NREQ*CNT-1:0]    i_num_cnt,
  output logic [NREQ-1:0]        o_ack,
  output logic [NREQ-1:0]        o_done,
  output logic [NREQ-1:0]        o_err,
  output logic                   o_busy,
  output logic [clog2(NREQ)-1:0] o_grant_id,
  output logic                   o_mv_run,
  output logic [CNT-1:0]         o_mv_num_cnt,
  input  logic                   i_mv_idle,
  input  logic                   i_mv_done,
  input  logic                   i_clr_stats,
  output logic [31:0]            o_job_cnt
);

  localparam int IDW = clog2(NREQ);

  state_t          state;
  logic [IDW-1:0]  last_grant;
  logic            err_flag;
  logic [NREQ-1:0] arb_gnt;
  logic [IDW-1:0]  arb_id;
  logic            arb_vld;
  logic [CNT-1:0]  sel_cnt;
  logic [NREQ-1:0] id_onehot;
  logic [31:0]     job_cnt;

  // Saturating increment for the completed-job statistic.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .i_req    (i_req),
    .i_last   (last_grant),
    .o_gnt    (arb_gnt),
    .o_gnt_id (arb_id),
    .o_vld    (arb_vld)
  );

  // Pick the count belonging to the requester the arbiter would grant.
  always_comb begin
    sel_cnt = '0;
    for (int k = 0; k < NREQ; k++)
      if (arb_gnt[k]) sel_cnt = i_num_cnt[k*CNT +: CNT];
  end

  // One-hot form of the owner of the job in flight.
  always_comb begin
    id_onehot             = '0;
    id_onehot[o_grant_id] = 1'b1;
  end

  // Job FSM; every output is registered and pulses are cleared by default.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      last_grant   <= IDW'(NREQ - 1);
      err_flag     <= 1'b0;
      o_grant_id   <= '0;
      o_mv_num_cnt <= '0;
      o_ack        <= '0;
      o_done       <= '0;
      o_err        <= '0;
      o_busy       <= 1'b0;
      o_mv_run     <= 1'b0;
    end else begin
      o_ack    <= '0;
      o_done   <= '0;
      o_err    <= '0;
      o_mv_run <= 1'b0;
      case (state)
        S_IDLE: begin
          if (arb_vld && i_mv_idle) begin
            o_grant_id   <= arb_id;
            o_mv_num_cnt <= sel_cnt;
            o_ack        <= arb_gnt;
            o_busy       <= 1'b1;
            if (sel_cnt == '0) begin
              // Nothing to move: answer immediately with an error.
              err_flag <= 1'b1;
              o_done   <= arb_gnt;
              o_err    <= arb_gnt;
              state    <= S_RESP;
            end else begin
              err_flag <= 1'b0;
              o_mv_run <= 1'b1;
              state    <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (i_mv_done) begin
            o_done <= id_onehot;
            o_err  <= err_flag ? id_onehot : '0;
            state  <= S_RESP;
          end
        end
        S_RESP: begin
          last_grant <= o_grant_id;
          o_busy     <= 1'b0;
          state      <= S_IDLE;
        end
        default: begin
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  // Completed-job counter; a clear request overrides a same-cycle increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      job_cnt <= '0;
    end else if (i_clr_stats) begin
      job_cnt <= '0;
    end else if (state == S_RESP && !err_flag) begin
      job_cnt <= sat_inc(job_cnt);
    end
  end

  assign o_job_cnt = job_cnt;

endmodule

// File: tb/tb_mover_scheduler.sv
// Scoreboard bench for mover_scheduler: stimulus pushes expected ack/run/done
// events, a negedge monitor pops and compares them as the DUT emits them.
module tb_mover_scheduler;

  localparam int CNT  = 31;
  localparam int NREQ = 4;

  typedef struct { logic [3:0] oh; int cyc; } ack_t;
  typedef struct { logic [30:0] cnt; logic [1:0] id; int cyc; } run_t;
  typedef struct { logic [3:0] oh; logic err; int cyc; } done_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NREQ-1:0]   i_req = '0;
  logic [NREQ*CNT-1:0] i_num_cnt = '0;
  logic [NREQ-1:0]   o_ack, o_done, o_err;
  logic              o_busy;
  logic [1:0]        o_grant_id;
  logic              o_mv_run;
  logic [CNT-1:0]    o_mv_num_cnt;
  logic              i_mv_idle = 1'b1;
  logic              i_mv_done = 1'b0;
  logic              i_clr_stats = 1'b0;
  logic [31:0]       o_job_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  ack_t  ack_q[$];
  run_t  run_q[$];
  done_t done_q[$];
  ack_t  mon_a;
  run_t  mon_r;
  done_t mon_d;

  logic [30:0] cnt_tab[4];
  int          exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  logic [31:0] exp_jobs;

  mover_scheduler #(.CNT(CNT), .NREQ(NREQ)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_req        (i_req),
    .i_num_cnt    (i_num_cnt),
    .o_ack        (o_ack),
    .o_done       (o_done),
    .o_err        (o_err),
    .o_busy       (o_busy),
    .o_grant_id   (o_grant_id),
    .o_mv_run     (o_mv_run),
    .o_mv_num_cnt (o_mv_num_cnt),
    .i_mv_idle    (i_mv_idle),
    .i_mv_done    (i_mv_done),
    .i_clr_stats  (i_clr_stats),
    .o_job_cnt    (o_job_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] onehot(input int id);
    return 4'b0001 << id;
  endfunction

  task automatic drive_cnts();
    for (int k = 0; k < NREQ; k++) i_num_cnt[k*CNT +: CNT] = cnt_tab[k];
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"},     o_ack, 0);
    check({tag, "_done"},    o_done, 0);
    check({tag, "_err"},     o_err, 0);
    check({tag, "_busy"},    o_busy, 0);
    check({tag, "_gid"},     o_grant_id, 0);
    check({tag, "_run"},     o_mv_run, 0);
    check({tag, "_numcnt"},  o_mv_num_cnt, 0);
    check({tag, "_jobcnt"},  o_job_cnt, 0);
  endtask

  task automatic expect_grant(input int id, input int at_cyc);
    ack_q.push_back('{onehot(id), at_cyc});
    run_q.push_back('{cnt_tab[id], 2'(id), at_cyc});
  endtask

  // Wait for the run pulse, play the mover for 'delay' cycles, then pulse done.
  task automatic finish_job(input int delay, input logic [3:0] req_run,
                            input logic [3:0] req_done, input logic clr,
                            input int id, output int dcyc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_mv_run && n < 100);
    check("run_seen", o_mv_run, 1);
    i_req = req_run;
    repeat (delay) @(negedge clk);
    i_mv_done = 1'b1;
    dcyc = cyc;
    done_q.push_back('{onehot(id), 1'b0, cyc + 1});
    @(negedge clk);
    i_mv_done   = 1'b0;
    i_req       = req_done;
    i_clr_stats = clr;
    @(negedge clk);
    i_clr_stats = 1'b0;
  endtask

  // Monitor: every output event must match the head of its queue.
  always @(negedge clk) begin
    if (reset_n) begin
      if (o_ack != '0) begin
        if (ack_q.size() == 0) check("ack_unexpected", o_ack, 0);
        else begin
          mon_a = ack_q.pop_front();
          check("ack_vec", o_ack, mon_a.oh);
          check("ack_cycle", cyc, mon_a.cyc);
        end
      end
      if (o_mv_run) begin
        if (run_q.size() == 0) check("run_unexpected", o_mv_run, 0);
        else begin
          mon_r = run_q.pop_front();
          check("run_numcnt", o_mv_num_cnt, mon_r.cnt);
          check("run_gid", o_grant_id, mon_r.id);
          check("run_cycle", cyc, mon_r.cyc);
          check("run_busy", o_busy, 1);
        end
      end
      if (o_done != '0) begin
        if (done_q.size() == 0) check("done_unexpected", o_done, 0);
        else begin
          mon_d = done_q.pop_front();
          check("done_vec", o_done, mon_d.oh);
          check("done_err", o_err, mon_d.err ? mon_d.oh : 4'b0000);
          check("done_cycle", cyc, mon_d.cyc);
        end
      end else if (o_err != '0) begin
        check("err_without_done", o_err, 0);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int dcyc;
    int nxt;
    cnt_tab = '{31'd16, 31'd5, 31'd7, 31'd9};
    drive_cnts();
    exp_jobs = 0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    reset_n = 1'b1;
    @(negedge clk);

    // Single job: requester 0, count 16, done 17 cycles after run
    i_req = 4'b0001;
    expect_grant(0, cyc + 1);
    finish_job(17, 4'b0000, 4'b0000, 1'b0, 0, dcyc);
    exp_jobs = 1;
    check("single_jobcnt", o_job_cnt, 32'd1);
    check("single_busy", o_busy, 0);
    check("single_gid_hold", o_grant_id, 0);

    // Contention after a fresh reset: expected order 0,1,2,3,0,1,2,3
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    exp_jobs = 0;
    i_req = 4'b1111;
    nxt = cyc + 1;
    for (int j = 0; j < 8; j++) begin
      expect_grant(exp_order[j], nxt);
      finish_job(3, 4'b1111, (j == 7) ? 4'b0000 : 4'b1111, 1'b0, exp_order[j], dcyc);
      exp_jobs = exp_jobs + 1;
      nxt = dcyc + 3;
    end
    check("cont_jobcnt", o_job_cnt, 32'd8);

    // Zero count: requester 2 rejected with ack/done/err together
    cnt_tab[2] = 31'd0;
    drive_cnts();
    i_req = 4'b0100;
    ack_q.push_back('{4'b0100, cyc + 1});
    done_q.push_back('{4'b0100, 1'b1, cyc + 1});
    @(negedge clk);
    i_req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    check("zero_jobcnt", o_job_cnt, 32'd8);
    check("zero_busy", o_busy, 0);
    check("zero_gid", o_grant_id, 2);
    cnt_tab[2] = 31'd7;
    drive_cnts();

    // Mover busy for 5 cycles: ack only after idle rises; req churn mid-flight
    i_mv_idle = 1'b0;
    i_req = 4'b0010;
    expect_grant(1, cyc + 6);
    repeat (5) @(negedge clk);
    check("busy_no_grant", o_busy, 0);
    i_mv_idle = 1'b1;
    finish_job(4, 4'b1101, 4'b0000, 1'b0, 1, dcyc);
    check("busy_jobcnt", o_job_cnt, 32'd9);

    // Reset while waiting on the mover: job abandoned, no done
    i_req = 4'b0001;
    expect_grant(0, cyc + 1);
    @(negedge clk);
    @(negedge clk);
    i_req = 4'b0000;
    repeat (3) @(negedge clk);
    check("midjob_busy_before", o_busy, 1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    i_req = 4'b1000;
    expect_grant(3, cyc + 1);
    finish_job(2, 4'b0000, 4'b0000, 1'b0, 3, dcyc);
    check("fresh_jobcnt", o_job_cnt, 32'd1);

    // Stats: saturation near all-ones, then clear coincident with S_RESP
    dut.job_cnt = 32'hFFFF_FFFE;
    i_req = 4'b0001;
    expect_grant(0, cyc + 1);
    finish_job(1, 4'b0000, 4'b0000, 1'b0, 0, dcyc);
    check("sat_first", o_job_cnt, 32'hFFFF_FFFF);
    i_req = 4'b0001;
    expect_grant(0, cyc + 1);
    finish_job(1, 4'b0000, 4'b0000, 1'b0, 0, dcyc);
    check("sat_hold", o_job_cnt, 32'hFFFF_FFFF);
    i_req = 4'b0010;
    expect_grant(1, cyc + 1);
    finish_job(2, 4'b0000, 4'b0000, 1'b1, 1, dcyc);
    check("clr_wins", o_job_cnt, 32'd0);

    repeat (3) @(negedge clk);
    check("ack_q_empty", ack_q.size(), 0);
    check("run_q_empty", run_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
